fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit_pkg.sv | 25 ++
 rtl/fwd_src_select.sv | 60 ++++++
 rtl/fwd_hazard_unit.sv | 113 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared widths, forward-select encoding and pipeline tag type
package fwd_hazard_unit_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_AW       = 5;
   localparam int DEF_N_SRC    = 2;
   localparam int DEF_MC_LAT_W = 4;

   typedef enum logic [2:0] {
      FWD_RF  = 3'd0,
      FWD_EX  = 3'd1,
      FWD_MEM = 3'd2,
      FWD_WB  = 3'd3,
      FWD_MC  = 3'd4
   } fwd_sel_e;

   // dst is sized by the default address width; narrower AW values are zero-extended into it
   typedef struct packed {
      logic              valid;
      logic [DEF_AW-1:0] dst;
      logic              wr_en;
      logic              is_load;
   } stage_tag_t;

endpackage

// File: rtl/fwd_src_select.sv
// rtl/fwd_src_select.sv - per-source match, priority and mux for one operand
module fwd_src_select
   import fwd_hazard_unit_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int AW       = DEF_AW,
   parameter int MC_LAT_W = DEF_MC_LAT_W
) (
   input  logic [AW-1:0]       src_i,
   input  logic                src_en_i,
   input  logic [DATA_W-1:0]   rf_data_i,
   input  stage_tag_t          tag_i [3],
   input  logic [DATA_W-1:0]   stage_data_i [3],
   input  logic [DATA_W-1:0]   mc_data_i,
   input  logic [MC_LAT_W-1:0] mc_cnt_i,
   input  logic [AW-1:0]       mc_dst_i,
   output logic [DATA_W-1:0]   fwd_data_o,
   output fwd_sel_e            fwd_sel_o,
   output logic                load_use_o,
   output logic                mc_wait_o
);

   logic       src_live;
   logic [2:0] hit;
   logic       mc_hit;

   assign src_live = src_en_i && (src_i != '0);
   assign mc_hit   = src_live && (mc_cnt_i != '0) && (mc_dst_i == src_i);

   always_comb begin
      hit = '0;
      for (int k = 0; k < 3; k++) begin
         hit[k] = src_live && tag_i[k].valid && tag_i[k].wr_en
                  && (tag_i[k].dst == DEF_AW'(src_i));
      end
   end

   // The multi-cycle result on its final cycle is the newest value of that register.
   always_comb begin
      fwd_sel_o  = FWD_RF;
      fwd_data_o = rf_data_i;
      if (mc_hit && (mc_cnt_i == MC_LAT_W'(1))) begin
         fwd_sel_o  = FWD_MC;
         fwd_data_o = mc_data_i;
      end else if (hit[0]) begin
         fwd_sel_o  = FWD_EX;
         fwd_data_o = stage_data_i[0];
      end else if (hit[1]) begin
         fwd_sel_o  = FWD_MEM;
         fwd_data_o = stage_data_i[1];
      end else if (hit[2]) begin
         fwd_sel_o  = FWD_WB;
         fwd_data_o = stage_data_i[2];
      end
   end

   assign load_use_o = hit[0] && tag_i[0].is_load;
   assign mc_wait_o  = mc_hit && (mc_cnt_i > MC_LAT_W'(1));

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding and load-use / multi-cycle hazard stall unit
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int AW       = DEF_AW,
   parameter int N_SRC    = DEF_N_SRC,
   parameter int MC_LAT_W = DEF_MC_LAT_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           id_valid,
   input  logic [N_SRC-1:0][AW-1:0]       id_src,
   input  logic [N_SRC-1:0]               id_src_en,
   input  logic [N_SRC-1:0][DATA_W-1:0]   id_rf_data,
   input  logic [AW-1:0]                  id_dst,
   input  logic                           id_wr_en,
   input  logic                           id_is_load,
   input  logic [MC_LAT_W-1:0]            id_mc_lat,
   input  logic [DATA_W-1:0]              ex_result,
   input  logic [DATA_W-1:0]              mem_result,
   input  logic [DATA_W-1:0]              wb_result,
   input  logic [DATA_W-1:0]              mc_result,
   input  logic                           flush,
   output logic [N_SRC-1:0][DATA_W-1:0]   fwd_data,
   output logic [N_SRC-1:0][2:0]          fwd_sel,
   output logic                           stall,
   output logic [15:0]                    stall_cnt
);

   stage_tag_t          tag_q [3];   // [0] EX, [1] MEM, [2] WB
   stage_tag_t          ex_d;
   logic [MC_LAT_W-1:0] mc_cnt_q, mc_cnt_d;
   logic [AW-1:0]       mc_dst_q, mc_dst_d;
   logic [15:0]         stall_cnt_q, stall_cnt_d;
   logic [DATA_W-1:0]   stage_data [3];
   logic [N_SRC-1:0]    load_use;
   logic [N_SRC-1:0]    mc_wait;
   logic                issue;

   assign stage_data[0] = ex_result;
   assign stage_data[1] = mem_result;
   assign stage_data[2] = wb_result;

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      fwd_sel_e sel;
      fwd_src_select #(
         .DATA_W   (DATA_W),
         .AW       (AW),
         .MC_LAT_W (MC_LAT_W)
      ) u_sel (
         .src_i        (id_src[i]),
         .src_en_i     (id_src_en[i]),
         .rf_data_i    (id_rf_data[i]),
         .tag_i        (tag_q),
         .stage_data_i (stage_data),
         .mc_data_i    (mc_result),
         .mc_cnt_i     (mc_cnt_q),
         .mc_dst_i     (mc_dst_q),
         .fwd_data_o   (fwd_data[i]),
         .fwd_sel_o    (sel),
         .load_use_o   (load_use[i]),
         .mc_wait_o    (mc_wait[i])
      );
      assign fwd_sel[i] = sel;
   end

   assign stall = id_valid && ((|load_use) || (|mc_wait)
                  || ((id_mc_lat != '0) && (mc_cnt_q != '0)));
   assign issue = id_valid && !stall && !flush;

   // Multi-cycle ops enter EX non-writing so only the mc path can ever forward them.
   always_comb begin
      ex_d         = '0;
      mc_cnt_d     = mc_cnt_q;
      mc_dst_d     = mc_dst_q;
      stall_cnt_d  = stall_cnt_q;
      if (issue) begin
         ex_d.valid   = 1'b1;
         ex_d.dst     = DEF_AW'(id_dst);
         ex_d.wr_en   = id_wr_en && (id_mc_lat == '0);
         ex_d.is_load = id_is_load;
      end
      if (issue && (id_mc_lat != '0)) begin
         mc_cnt_d = id_mc_lat;
         mc_dst_d = id_dst;
      end else if (mc_cnt_q != '0) begin
         mc_cnt_d = mc_cnt_q - MC_LAT_W'(1);
      end
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) tag_q[k] <= '0;
         mc_cnt_q    <= '0;
         mc_dst_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         tag_q[0]    <= ex_d;
         tag_q[1]    <= tag_q[0];
         tag_q[2]    <= tag_q[1];
         mc_cnt_q    <= mc_cnt_d;
         mc_dst_q    <= mc_dst_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for fwd_hazard_unit against an issue-history model
module tb_fwd_hazard_unit;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NS = 2;
   localparam int LW = 4;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      id_valid = 1'b0;
   logic [NS-1:0][AW-1:0]     id_src = '0;
   logic [NS-1:0]             id_src_en = '0;
   logic [NS-1:0][DW-1:0]     id_rf_data = '0;
   logic [AW-1:0]             id_dst = '0;
   logic                      id_wr_en = 1'b0;
   logic                      id_is_load = 1'b0;
   logic [LW-1:0]             id_mc_lat = '0;
   logic [DW-1:0]             ex_result = '0, mem_result = '0, wb_result = '0, mc_result = '0;
   logic                      flush = 1'b0;
   logic [NS-1:0][DW-1:0]     fwd_data;
   logic [NS-1:0][2:0]        fwd_sel;
   logic                      stall;
   logic [15:0]               stall_cnt;

   fwd_hazard_unit #(.DATA_W(DW), .AW(AW), .N_SRC(NS), .MC_LAT_W(LW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_en(id_src_en),
      .id_rf_data(id_rf_data), .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
      .id_mc_lat(id_mc_lat), .ex_result(ex_result), .mem_result(mem_result),
      .wb_result(wb_result), .mc_result(mc_result), .flush(flush),
      .fwd_data(fwd_data), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NS-1:0][2:0]    sel;
      logic [NS-1:0][DW-1:0] data;
      logic                  stall;
      logic [15:0]           cnt;
   } exp_t;

   typedef struct {
      bit v;
      int dst;
      bit wr;
      bit ld;
   } ins_t;

   exp_t    exp_q[$];
   int      errors = 0;
   int      checks = 0;

   // Model: the last three issue slots (newest first), the cycle at which the
   // pending multi-cycle result is due, and the stall count.
   ins_t    hist[$];
   longint  cyc;
   longint  mc_due;
   int      mc_dst;
   int      m_cnt;

   task automatic model_reset();
      ins_t b;
      b.v = 0; b.dst = 0; b.wr = 0; b.ld = 0;
      hist = {};
      for (int k = 0; k < 3; k++) hist.push_back(b);
      mc_due = -1;
      mc_dst = 0;
      m_cnt  = 0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_cycle();
      exp_t e;
      bit   lu, mw, st, busy, iss;
      ins_t n;
      lu = 0; mw = 0;
      e = '0;
      if (!rst_n) model_reset();
      busy = (cyc <= mc_due);
      for (int i = 0; i < NS; i++) begin
         int s;
         bit live, mhit;
         int pick;
         s    = int'(id_src[i]);
         live = id_src_en[i] && (s != 0);
         mhit = live && busy && (mc_dst == s);
         pick = 0;
         if (mhit && cyc == mc_due) pick = 4;
         else
            for (int k = 0; k < 3; k++)
               if (pick == 0 && live && hist[k].v && hist[k].wr && hist[k].dst == s) pick = k + 1;
         if (live && hist[0].v && hist[0].wr && hist[0].dst == s && hist[0].ld) lu = 1;
         if (mhit && cyc < mc_due) mw = 1;
         e.sel[i] = 3'(pick);
         case (pick)
            1:       e.data[i] = ex_result;
            2:       e.data[i] = mem_result;
            3:       e.data[i] = wb_result;
            4:       e.data[i] = mc_result;
            default: e.data[i] = id_rf_data[i];
         endcase
      end
      st = id_valid && (lu || mw || (id_mc_lat != 0 && busy));
      e.stall = st;
      e.cnt   = 16'(m_cnt);
      exp_q.push_back(e);
      if (rst_n) begin
         iss  = id_valid && !st && !flush;
         n.v  = iss;
         n.dst = iss ? int'(id_dst) : 0;
         n.wr = iss && id_wr_en && (id_mc_lat == 0);
         n.ld = iss && id_is_load;
         hist.push_front(n);
         void'(hist.pop_back());
         if (iss && id_mc_lat != 0) begin
            mc_due = cyc + longint'(id_mc_lat);
            mc_dst = int'(id_dst);
         end
         if (st && m_cnt < 65535) m_cnt++;
      end
      cyc++;
   endtask

   task automatic step(input bit v, input int s0, input bit e0, input int s1, input bit e1,
                       input int dst, input bit wr, input bit ld, input int lat, input bit fl,
                       input bit rs = 1'b1);
      @(negedge clk);
      rst_n         = rs;
      id_valid      = v;
      id_src[0]     = AW'(s0);
      id_src[1]     = AW'(s1);
      id_src_en     = {e1, e0};
      id_dst        = AW'(dst);
      id_wr_en      = wr;
      id_is_load    = ld;
      id_mc_lat     = LW'(lat);
      flush         = fl;
      id_rf_data[0] = $urandom;
      id_rf_data[1] = $urandom;
      ex_result     = $urandom;
      mem_result    = $urandom;
      wb_result     = $urandom;
      mc_result     = $urandom;
      #1;
      model_cycle();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
            for (int i = 0; i < NS; i++) begin
               chk($sformatf("fwd_sel[%0d]", i), 32'(fwd_sel[i]), 32'(e.sel[i]));
               chk($sformatf("fwd_data[%0d]", i), fwd_data[i], e.data[i]);
            end
         end
      end
   end

   initial begin : driver
      int guard;
      cyc = 0;
      model_reset();
      for (int k = 0; k < 3; k++) step(1, 3, 1, 4, 1, 3, 1, 0, 2, 0, 0);
      step(1, 3, 1, 4, 1, 3, 1, 0, 0, 0);             // first instruction after reset
      // EX forward, then EX over MEM priority
      step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      step(1, 3, 1, 0, 0, 8, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      step(1, 3, 1, 3, 1, 9, 1, 0, 0, 0);
      // load-use: stall once, then MEM forward
      step(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
      step(1, 4, 1, 1, 1, 10, 1, 0, 0, 0);
      step(1, 4, 1, 1, 1, 10, 1, 0, 0, 0);
      // multi-cycle: structural stall, dependent stall, mc forward
      step(1, 0, 0, 0, 0, 5, 1, 0, 3, 0);
      step(1, 0, 0, 0, 0, 6, 1, 0, 2, 0);
      step(1, 5, 1, 0, 0, 11, 1, 0, 0, 0);
      step(1, 5, 1, 0, 0, 11, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 6, 1, 0, 2, 0);
      step(1, 6, 1, 5, 1, 12, 1, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // r0 never forwards; flush during a load-use stall
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 1, 13, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
      step(1, 4, 1, 0, 0, 14, 1, 0, 0, 1);
      step(1, 4, 1, 0, 0, 14, 1, 0, 0, 0);
      // reset in the middle of a multi-cycle stall
      step(1, 0, 0, 0, 0, 7, 1, 0, 6, 0);
      step(1, 7, 1, 0, 0, 15, 1, 0, 0, 0);
      step(1, 7, 1, 0, 0, 15, 1, 0, 0, 0);
      step(1, 7, 1, 0, 0, 15, 1, 0, 0, 0, 0);
      step(1, 7, 1, 0, 0, 15, 1, 0, 0, 0);
      // randomized traffic over a small register window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         step(($urandom % 4) != 0, $urandom % 8, $urandom % 2, $urandom % 8, $urandom % 2,
              $urandom % 8, $urandom % 2, ($urandom % 4) == 0,
              (($urandom % 6) == 0) ? 1 + $urandom % 4 : 0, ($urandom % 10) == 0,
              ($urandom % 150) != 0);
      end
      // saturate the stall counter with back-to-back long multi-cycle ops
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      guard = 0;
      while (m_cnt < 65535 && guard < 80000) begin
         step(1, 0, 0, 0, 0, 9, 1, 0, 15, 0);
         guard++;
      end
      repeat (20) step(1, 0, 0, 0, 0, 9, 1, 0, 15, 0);
      chk("sat_reached", 32'(m_cnt), 32'd65535);
      @(negedge clk);
      #5;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
